// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART program loader:
//   SYNC_BYTE   - frame start marker
//   ld_state_t  - frame FSM states
//   rx_state_t  - byte receiver states
//   calc_div    - clock cycles per UART bit
//   word_count  - decoded/clipped word count of a frame
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4,
    ST_ABORT  = 3'd5
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per bit on the line.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Count byte 0 means 256 words; never more words than the memory holds.
  function automatic logic [8:0] word_count(input logic [7:0] n, input int addr_w);
    logic [8:0] full;
    logic [8:0] lim;
    full = (n == 8'd0) ? 9'd256 : {1'b0, n};
    if (addr_w < 8) begin
      lim = 9'd1 << addr_w;
      if (full > lim) begin
        full = lim;
      end else begin
        full = full;
      end
    end else begin
      lim = 9'd256;
    end
    return full;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte receiver with a 2-flop input synchroniser.
//   clk, rst_n  : system clock, async active-low reset
//   rx          : serial line, idle high, asynchronous
//   byte_valid  : one-cycle pulse, byte_data valid
//   byte_data   : received byte
//   ferr        : one-cycle pulse when the stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_ferr;
  logic            w_ferr_nxt;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;

  // Synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state, baud counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic: mid-bit sampling relative to the detected start edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (r_prev && !r_sync2) begin
          w_state_nxt = RX_START;
        end else begin
          w_state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          w_bit_nxt = 3'd0;
          // A start bit that is gone by mid-bit was a glitch.
          if (!r_sync2) begin
            w_state_nxt = RX_DATA;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end else begin
          w_state_nxt = RX_START;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_state_nxt = RX_DATA;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_M1) begin
          // Return to idle at mid-stop so a back-to-back start edge is caught.
          w_state_nxt = RX_IDLE;
          w_cnt_nxt   = '0;
          if (r_sync2) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = RX_STOP;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign byte_valid = r_valid;
  assign byte_data  = r_data;
  assign ferr       = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Receives A5 | N | N*4 data bytes (MSB first) | XOR checksum over UART and
// writes the assembled 32-bit words to consecutive memory word addresses.
//   clk, rst_n   : system clock, async active-low reset
//   rx           : UART line, idle high
//   mem_we       : one-cycle write strobe
//   mem_addr     : word address, held until the next write
//   mem_wdata    : word data, held until the next write
//   load_active  : frame in progress (holds the CPU in reset)
//   done         : sticky, last frame completed with good checksum
//   err          : sticky, last frame aborted
// -----------------------------------------------------------------------------
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_active,
  output logic              done,
  output logic              err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_ferr;

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic [8:0]        r_count;
  logic [8:0]        w_count_nxt;
  logic [8:0]        r_words;
  logic [8:0]        w_words_nxt;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_nxt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_nxt;
  logic [7:0]        r_csum;
  logic [7:0]        w_csum_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] r_maddr;
  logic [ADDR_W-1:0] w_maddr_nxt;
  logic [31:0]       r_wdata;
  logic [31:0]       w_wdata_nxt;
  logic              r_load;
  logic              w_load_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .ferr       (w_ferr)
  );

  // Frame FSM state, word assembly and registered memory/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= 9'd0;
      r_words <= 9'd0;
      r_idx   <= 2'd0;
      r_word  <= 32'd0;
      r_csum  <= 8'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_maddr <= '0;
      r_wdata <= 32'd0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_words <= w_words_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_csum  <= w_csum_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_maddr <= w_maddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_load  <= w_load_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Frame FSM next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_words_nxt = r_words;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_csum_nxt  = r_csum;
    w_addr_nxt  = r_addr;
    w_we_nxt    = 1'b0;
    w_maddr_nxt = r_maddr;
    w_wdata_nxt = r_wdata;
    w_load_nxt  = r_load;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        // Framing errors and non-sync bytes are ignored here.
        if (w_byte_valid && (w_byte_data == SYNC_BYTE)) begin
          w_state_nxt = ST_COUNT;
          w_load_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_addr_nxt  = '0;
          w_csum_nxt  = 8'd0;
          w_words_nxt = 9'd0;
          w_idx_nxt   = 2'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (w_ferr) begin
          w_state_nxt = ST_ABORT;
        end else if (w_byte_valid) begin
          w_count_nxt = word_count(w_byte_data, ADDR_W);
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_DATA: begin
        if (w_ferr) begin
          w_state_nxt = ST_ABORT;
        end else if (w_byte_valid) begin
          w_word_nxt = {r_word[23:0], w_byte_data};
          w_csum_nxt = r_csum ^ w_byte_data;
          w_idx_nxt  = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_we_nxt    = 1'b1;
            w_maddr_nxt = r_addr;
            w_wdata_nxt = {r_word[23:0], w_byte_data};
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_words_nxt = r_words + 9'd1;
            if ((r_words + 9'd1) == r_count) begin
              w_state_nxt = ST_CHECK;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (w_ferr) begin
          w_state_nxt = ST_ABORT;
        end else if (w_byte_valid) begin
          if (w_byte_data == r_csum) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_ABORT;
          end
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_FINISH: begin
        // load_active falls in the same cycle the status flag rises.
        w_done_nxt  = 1'b1;
        w_load_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        w_err_nxt   = 1'b1;
        w_load_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_load_nxt  = 1'b0;
      end
    endcase
  end

  assign mem_we      = r_we;
  assign mem_addr    = r_maddr;
  assign mem_wdata   = r_wdata;
  assign load_active = r_load;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
module tb_uart_prog_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_active;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Stream of bytes put on the line since the last checkpoint.
  logic [7:0]  tx_b[$];
  bit          tx_bad[$];
  // Observed writes and reference-model writes, {addr, data}.
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_active = 1'b0;
  int          overlap_cnt = 0;
  int          bv_cnt = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_HZ (1_000_000),
    .BAUD   (100_000),
    .ADDR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .load_active (load_active),
    .done        (done),
    .err         (err)
  );

  always @(negedge clk) begin
    if (mem_we) obs_q.push_back({mem_addr, mem_wdata});
    if (load_active && (done || err)) overlap_cnt++;
    if (dut.w_byte_valid) bv_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle(input int c);
    rx = 1'b1;
    repeat (c) @(negedge clk);
  endtask

  // bad=1 drives the stop bit low, then one idle bit so the next start edge exists.
  task automatic send_byte(input logic [7:0] b, input bit bad);
    bit_time(1'b0);
    for (int k = 0; k < 8; k++) bit_time(b[k]);
    bit_time(bad ? 1'b0 : 1'b1);
    if (bad) bit_time(1'b1);
    tx_b.push_back(b);
    tx_bad.push_back(bad);
  endtask

  // Reference: parse the byte stream by the frame rules.
  task automatic run_model();
    int i;
    int n;
    int addr;
    logic [7:0]  cs;
    logic [31:0] w;
    bit stop;
    exp_q.delete();
    i = 0;
    while (i < tx_b.size()) begin
      if (tx_bad[i] || tx_b[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      m_done = 1'b0; m_err = 1'b0; m_active = 1'b1;
      addr = 0; cs = 8'd0; stop = 1'b0;
      if (i >= tx_b.size()) break;
      if (tx_bad[i]) begin
        m_err = 1'b1; m_active = 1'b0; i++;
        continue;
      end
      n = (tx_b[i] == 8'd0) ? 256 : int'(tx_b[i]);
      i++;
      for (int wi = 0; wi < n && !stop; wi++) begin
        w = 32'd0;
        for (int k = 0; k < 4 && !stop; k++) begin
          if (i >= tx_b.size()) begin
            stop = 1'b1;
          end else if (tx_bad[i]) begin
            stop = 1'b1; m_err = 1'b1; m_active = 1'b0; i++;
          end else begin
            w = {w[23:0], tx_b[i]};
            cs = cs ^ tx_b[i];
            i++;
            if (k == 3) begin
              exp_q.push_back({8'(addr), w});
              addr++;
            end
          end
        end
      end
      if (stop) continue;
      if (i >= tx_b.size()) break;
      if (!tx_bad[i] && tx_b[i] == cs) m_done = 1'b1;
      else m_err = 1'b1;
      m_active = 1'b0;
      i++;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    idle(3 * DIV);
    run_model();
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, obs_q[i], exp_q[i]);
    check({tag, "_done"}, done, m_done);
    check({tag, "_err"}, err, m_err);
    check({tag, "_load"}, load_active, m_active);
    check({tag, "_overlap"}, overlap_cnt, 0);
    tx_b.delete(); tx_bad.delete(); obs_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_addr"}, mem_addr, 8'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_load"}, load_active, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [7:0] d[$], input logic [7:0] cs);
    send_byte(8'hA5, 1'b0);
    send_byte(n, 1'b0);
    foreach (d[i]) send_byte(d[i], 1'b0);
    send_byte(cs, 1'b0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] b;
    logic [7:0] cs;
    int bv0;
    int nw;
    bit aborted;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle(5);

    // 1: good two-word frame
    d = '{8'h28, 8'h1F, 8'h00, 8'h01, 8'h28, 8'h1F, 8'h00, 8'h02};
    send_frame(8'h02, d, 8'h03);
    check("t1_w0", {obs_q.size() > 0 ? obs_q[0] : 40'd0}, {8'h00, 32'h281F0001});
    check("t1_w1", {obs_q.size() > 1 ? obs_q[1] : 40'd0}, {8'h01, 32'h281F0002});
    check_all("t1");

    // 2: bad checksum
    send_frame(8'h02, d, 8'h00);
    check_all("t2");

    // 3: garbage before sync
    send_byte(8'h3C, 1'b0);
    send_byte(8'h11, 1'b0);
    check_all("t3a");
    send_frame(8'h01, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    check_all("t3b");

    // 4: framing error on 3rd data byte, then a good frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h28, 1'b0);
    send_byte(8'h1F, 1'b0);
    send_byte(8'h00, 1'b1);
    check_all("t4a");
    send_frame(8'h02, d, 8'h03);
    check_all("t4b");

    // 5: one-cycle glitch in idle
    bv0 = bv_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(3 * DIV);
    check("t5_bv", bv_cnt - bv0, 0);
    check_all("t5");

    // 6: reset in the middle of DATA
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(d[i], 1'b0);
    check_all("t6a");
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_done = 1'b0; m_err = 1'b0; m_active = 1'b0;
    tx_b.delete(); tx_bad.delete(); obs_q.delete();
    idle(5);
    send_frame(8'h02, d, 8'h03);
    check_all("t6b");

    // Randomized frames: garbage, random sizes, random checksum/stop faults
    for (int it = 0; it < 10; it++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, ($urandom_range(0, 9) == 0));
      end
      nw = $urandom_range(1, 3);
      aborted = 1'b0;
      cs = 8'd0;
      send_byte(8'hA5, 1'b0);
      send_byte(8'(nw), 1'b0);
      for (int i = 0; i < nw * 4 && !aborted; i++) begin
        b = 8'($urandom_range(0, 255));
        cs = cs ^ b;
        aborted = ($urandom_range(0, 19) == 0);
        send_byte(b, aborted);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 15));
      end
      if (!aborted) begin
        if ($urandom_range(0, 1) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        send_byte(cs, 1'b0);
      end
      check_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
